// File: rtl/fft16_pkg.sv
// ============================================================================
// Module   : fft16_pkg
// Purpose  : Shared sizes, FSM state encoding and index helper for the
//            fft16 streaming adapter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fft16_pkg;

  localparam int N      = 16;
  localparam int DATA_W = 12;
  localparam int GAIN_W = 4;
  localparam int OUT_W  = DATA_W + GAIN_W;
  localparam int IDX_W  = $clog2(N);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(N - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft16_frame_buf.sv
// ============================================================================
// Module   : fft16_frame_buf
// Purpose  : N-entry signed complex register file with indexed write and a
//            whole-frame parallel load; every entry is visible on the outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft16_frame_buf
  import fft16_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic signed [W-1:0] wr_re_i,
  input  logic signed [W-1:0] wr_im_i,
  input  logic                ld_en_i,
  input  logic signed [W-1:0] ld_re_i [N],
  input  logic signed [W-1:0] ld_im_i [N],
  output logic signed [W-1:0] q_re_o  [N],
  output logic signed [W-1:0] q_im_o  [N]
);

  logic signed [W-1:0] re_q [N];
  logic signed [W-1:0] im_q [N];

  // A parallel load wins over an indexed write in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (ld_en_i) begin
      for (int i = 0; i < N; i++) begin
        re_q[i] <= ld_re_i[i];
        im_q[i] <= ld_im_i[i];
      end
    end else if (wr_en_i) begin
      re_q[wr_idx_i] <= wr_re_i;
      im_q[wr_idx_i] <= wr_im_i;
    end
  end

  assign q_re_o = re_q;
  assign q_im_o = im_q;

endmodule

`default_nettype wire

// File: rtl/fft16_stream_adapter.sv
// ============================================================================
// Module   : fft16_stream_adapter
// Purpose  : Collects N streamed samples into a frame, launches one FFT/IFFT
//            run on the core and replays the captured result as N beats.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft16_stream_adapter
  import fft16_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_real,
  input  logic signed [DATA_W-1:0] s_imag,
  input  logic                     s_last,
  input  logic                     s_mode,
  output logic                     fft_start,
  output logic                     fft_mode,
  output logic signed [DATA_W-1:0] fft_real_in  [N],
  output logic signed [DATA_W-1:0] fft_imag_in  [N],
  input  logic signed [OUT_W-1:0]  fft_real_out [N],
  input  logic signed [OUT_W-1:0]  fft_imag_out [N],
  input  logic                     fft_done,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_real,
  output logic signed [OUT_W-1:0]  m_imag,
  output logic [IDX_W-1:0]         m_index,
  output logic                     m_last,
  output logic                     frame_err
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e                  state_q;
  logic [IDX_W-1:0]        wr_idx_q;
  logic [IDX_W-1:0]        rd_idx_q;
  logic [IDX_W-1:0]        rd_idx_d;
  logic [CNT_W-1:0]        to_cnt_q;
  logic                    done_q;
  logic                    s_ready_q;
  logic                    fft_start_q;
  logic                    fft_mode_q;
  logic                    m_valid_q;
  logic signed [OUT_W-1:0] m_real_q;
  logic signed [OUT_W-1:0] m_imag_q;
  logic [IDX_W-1:0]        m_index_q;
  logic                    m_last_q;
  logic                    frame_err_q;

  logic                     accept;
  logic                     done_rise;
  logic                     capture;
  logic signed [DATA_W-1:0] no_load   [N];
  logic signed [OUT_W-1:0]  obuf_re   [N];
  logic signed [OUT_W-1:0]  obuf_im   [N];

  assign accept    = (state_q == FILL) && s_valid && s_ready_q;
  assign done_rise = fft_done && !done_q;
  assign capture   = (state_q == WAIT) && done_rise;
  assign rd_idx_d  = rd_idx_q + IDX_W'(1);

  always_comb begin
    for (int i = 0; i < N; i++) no_load[i] = '0;
  end

  fft16_frame_buf #(.W(DATA_W)) u_in_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (accept),
    .wr_idx_i (wr_idx_q),
    .wr_re_i  (s_real),
    .wr_im_i  (s_imag),
    .ld_en_i  (1'b0),
    .ld_re_i  (no_load),
    .ld_im_i  (no_load),
    .q_re_o   (fft_real_in),
    .q_im_o   (fft_imag_in)
  );

  fft16_frame_buf #(.W(OUT_W)) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (1'b0),
    .wr_idx_i ('0),
    .wr_re_i  ('0),
    .wr_im_i  ('0),
    .ld_en_i  (capture),
    .ld_re_i  (fft_real_out),
    .ld_im_i  (fft_imag_out),
    .q_re_o   (obuf_re),
    .q_im_o   (obuf_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      to_cnt_q    <= '0;
      done_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      fft_start_q <= 1'b0;
      fft_mode_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_real_q    <= '0;
      m_imag_q    <= '0;
      m_index_q   <= '0;
      m_last_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q      <= fft_done;
      fft_start_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q   <= FILL;
          s_ready_q <= 1'b1;
          wr_idx_q  <= '0;
        end
        FILL: begin
          if (accept) begin
            if (wr_idx_q == '0) fft_mode_q <= s_mode;
            if (is_last_idx(wr_idx_q)) begin
              state_q     <= START;
              s_ready_q   <= 1'b0;
              fft_start_q <= 1'b1;
              wr_idx_q    <= '0;
              frame_err_q <= !s_last;
            end else if (s_last) begin
              frame_err_q <= 1'b1;
              wr_idx_q    <= '0;
            end else begin
              wr_idx_q <= wr_idx_q + IDX_W'(1);
            end
          end
        end
        START: begin
          // The START cycle itself counts toward the timeout budget.
          state_q  <= WAIT;
          to_cnt_q <= CNT_W'(1);
        end
        WAIT: begin
          if (done_rise) begin
            state_q  <= DRAIN;
            rd_idx_q <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            frame_err_q <= 1'b1;
            state_q     <= FILL;
            s_ready_q   <= 1'b1;
            wr_idx_q    <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (!m_valid_q) begin
            m_valid_q <= 1'b1;
            m_real_q  <= obuf_re[rd_idx_q];
            m_imag_q  <= obuf_im[rd_idx_q];
            m_index_q <= rd_idx_q;
            m_last_q  <= is_last_idx(rd_idx_q);
          end else if (m_ready) begin
            if (is_last_idx(rd_idx_q)) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              state_q   <= FILL;
              s_ready_q <= 1'b1;
              wr_idx_q  <= '0;
              rd_idx_q  <= '0;
            end else begin
              rd_idx_q  <= rd_idx_d;
              m_real_q  <= obuf_re[rd_idx_d];
              m_imag_q  <= obuf_im[rd_idx_d];
              m_index_q <= rd_idx_d;
              m_last_q  <= is_last_idx(rd_idx_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign fft_start = fft_start_q;
  assign fft_mode  = fft_mode_q;
  assign m_valid   = m_valid_q;
  assign m_real    = m_real_q;
  assign m_imag    = m_imag_q;
  assign m_index   = m_index_q;
  assign m_last    = m_last_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fft16_stream_adapter.sv
// ============================================================================
// Module   : tb_fft16_stream_adapter
// Purpose  : Self-checking bench with a behavioural DFT core and reference.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft16_stream_adapter;
  import fft16_pkg::*;

  localparam int  TO  = 20;
  localparam int  LAT = 6;
  localparam real PI  = 3.14159265358979;

  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_ready, s_last, s_mode;
  logic signed [DATA_W-1:0] s_real, s_imag;
  logic fft_start, fft_mode, fft_done;
  logic signed [DATA_W-1:0] fft_real_in  [N];
  logic signed [DATA_W-1:0] fft_imag_in  [N];
  logic signed [OUT_W-1:0]  fft_real_out [N];
  logic signed [OUT_W-1:0]  fft_imag_out [N];
  logic m_valid, m_ready, m_last, frame_err;
  logic signed [OUT_W-1:0] m_real, m_imag;
  logic [IDX_W-1:0] m_index;

  int n_tests = 0;
  int n_fail  = 0;
  int src_re[N], src_im[N], exp_re[N], exp_im[N];
  int pend_re[N], pend_im[N];
  int core_cnt;
  bit core_dead = 1'b0;
  bit core_run_dead;

  always #5 clk = ~clk;

  fft16_stream_adapter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .s_last(s_last), .s_mode(s_mode),
    .fft_start(fft_start), .fft_mode(fft_mode),
    .fft_real_in(fft_real_in), .fft_imag_in(fft_imag_in),
    .fft_real_out(fft_real_out), .fft_imag_out(fft_imag_out),
    .fft_done(fft_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last), .frame_err(frame_err)
  );

  // Direct DFT (forward) or 1/N-scaled inverse DFT, rounded to nearest.
  function automatic int dft(input int xr[N], input int xi[N], input int k,
                             input bit inv, input bit want_im);
    real acc, th, c, s;
    acc = 0.0;
    for (int n = 0; n < N; n++) begin
      th = 2.0 * PI * real'(n * k) / real'(N);
      c  = $cos(th);
      s  = $sin(th);
      if (!inv)
        acc += want_im ? (real'(xi[n]) * c - real'(xr[n]) * s)
                       : (real'(xr[n]) * c + real'(xi[n]) * s);
      else
        acc += want_im ? (real'(xi[n]) * c + real'(xr[n]) * s)
                       : (real'(xr[n]) * c - real'(xi[n]) * s);
    end
    if (inv) acc = acc / real'(N);
    return (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(0.5 - acc);
  endfunction

  // Core model: results appear LAT cycles after start; a stale done stays
  // high for two cycles into the new run before dropping.
  initial begin
    int tr[N], ti[N];
    fft_done = 1'b0;
    core_cnt = 0;
    for (int k = 0; k < N; k++) begin
      fft_real_out[k] = '0;
      fft_imag_out[k] = '0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        fft_done = 1'b0;
        core_cnt = 0;
      end else if (fft_start) begin
        for (int k = 0; k < N; k++) begin
          tr[k] = int'(fft_real_in[k]);
          ti[k] = int'(fft_imag_in[k]);
        end
        for (int k = 0; k < N; k++) begin
          pend_re[k] = dft(tr, ti, k, fft_mode, 1'b0);
          pend_im[k] = dft(tr, ti, k, fft_mode, 1'b1);
        end
        core_run_dead = core_dead;
        core_cnt      = LAT;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == LAT - 2) fft_done = 1'b0;
        if (core_cnt == 0 && !core_run_dead) begin
          for (int k = 0; k < N; k++) begin
            fft_real_out[k] = OUT_W'(pend_re[k]);
            fft_imag_out[k] = OUT_W'(pend_im[k]);
          end
          fft_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic randomize_src();
    for (int k = 0; k < N; k++) begin
      src_re[k] = int'($urandom_range(0, 2000)) - 1000;
      src_im[k] = int'($urandom_range(0, 2000)) - 1000;
    end
  endtask

  // s_mode is deliberately inverted after sample 0 so only sample 0 counts.
  task automatic send_frame(input int nsamp, input int last_at, input bit mode);
    for (int i = 0; i < nsamp; i++) begin
      int g;
      s_valid = 1'b1;
      s_real  = DATA_W'(src_re[i]);
      s_imag  = DATA_W'(src_im[i]);
      s_last  = (i == last_at);
      s_mode  = (i == 0) ? mode : ~mode;
      g = 0;
      while (!s_ready && g < 200) begin tick(); g++; end
      n_tests++;
      if (!s_ready) begin
        n_fail++;
        $display("FAIL send_ready sample=%0d got=0 want=1", i);
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // pat: 0 always ready, 1 alternating 1,0,.., 2 random
  task automatic collect_frame(input int pat);
    int beat, guard, ph;
    logic signed [OUT_W-1:0] hr, hi;
    logic [IDX_W-1:0] hx;
    bit held;
    beat = 0; guard = 0; ph = 0; held = 1'b0;
    hr = '0; hi = '0; hx = '0;
    m_ready = 1'b0;
    while (!(fft_done && core_cnt == 0) && guard < 100) begin tick(); guard++; end
    n_tests++;
    if (!(fft_done && core_cnt == 0)) begin
      n_fail++;
      $display("FAIL done_wait core never finished");
    end
    tick();
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early m_valid got=%b want=0", m_valid); end
    tick();
    n_tests++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid m_valid got=%b want=1", m_valid); end
    guard = 0;
    while (beat < N && guard < 400) begin
      if (held) begin
        n_tests++;
        if (m_real !== hr || m_imag !== hi || m_index !== hx) begin
          n_fail++;
          $display("FAIL hold beat=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                   beat, m_real, m_imag, m_index, hr, hi, hx);
        end
      end
      case (pat)
        0:       m_ready = 1'b1;
        1:       m_ready = (ph % 2 == 0);
        default: m_ready = $urandom_range(0, 1) == 1;
      endcase
      ph++;
      n_tests++;
      if (s_ready !== 1'b0) begin n_fail++; $display("FAIL drain_s_ready got=%b want=0", s_ready); end
      if (m_valid) begin
        if (m_ready) begin
          n_tests++;
          if (int'(m_real) !== exp_re[beat] || int'(m_imag) !== exp_im[beat] ||
              m_index !== IDX_W'(beat) || m_last !== (beat == N - 1)) begin
            n_fail++;
            $display("FAIL beat=%0d got re=%0d im=%0d idx=%0d last=%b want re=%0d im=%0d idx=%0d last=%b",
                     beat, m_real, m_imag, m_index, m_last,
                     exp_re[beat], exp_im[beat], beat, (beat == N - 1));
          end
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hr = m_real; hi = m_imag; hx = m_index;
        end
      end
      tick();
      guard++;
    end
    m_ready = 1'b0;
    n_tests++;
    if (beat != N) begin n_fail++; $display("FAIL beat_count got=%0d want=%0d", beat, N); end
    n_tests++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end m_valid=%b s_ready=%b want 0/1", m_valid, s_ready);
    end
  endtask

  task automatic run_frame(input bit mode, input int pat, input int last_at);
    int mism;
    for (int k = 0; k < N; k++) begin
      exp_re[k] = dft(src_re, src_im, k, mode, 1'b0);
      exp_im[k] = dft(src_re, src_im, k, mode, 1'b1);
    end
    send_frame(N, last_at, mode);
    n_tests++;
    if (fft_start !== 1'b1 || fft_mode !== mode || s_ready !== 1'b0 ||
        frame_err !== (last_at != N - 1)) begin
      n_fail++;
      $display("FAIL launch start=%b mode=%b s_ready=%b err=%b want 1/%b/0/%b",
               fft_start, fft_mode, s_ready, frame_err, mode, (last_at != N - 1));
    end
    mism = 0;
    for (int k = 0; k < N; k++)
      if (int'(fft_real_in[k]) !== src_re[k] || int'(fft_imag_in[k]) !== src_im[k]) mism++;
    n_tests++;
    if (mism != 0) begin n_fail++; $display("FAIL launch_frame bad_entries got=%0d want=0", mism); end
    tick();
    n_tests++;
    if (fft_start !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_width start=%b err=%b want 0/0", fft_start, frame_err);
    end
    collect_frame(pat);
  endtask

  task automatic test_reset();
    int nz;
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if ({s_ready, fft_start, fft_mode, m_valid, m_last, frame_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=000000",
               {s_ready, fft_start, fft_mode, m_valid, m_last, frame_err});
    end
    n_tests++;
    if (m_real !== '0 || m_imag !== '0 || m_index !== '0) begin
      n_fail++;
      $display("FAIL reset_beat got=%0d/%0d/%0d want=0/0/0", m_real, m_imag, m_index);
    end
    nz = 0;
    for (int k = 0; k < N; k++) if (fft_real_in[k] !== '0 || fft_imag_in[k] !== '0) nz++;
    n_tests++;
    if (nz != 0) begin n_fail++; $display("FAIL reset_frame nonzero got=%0d want=0", nz); end
    rst = 1'b0;
    n_tests++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready got=%b want=0", s_ready); end
    tick();
    n_tests++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_impulse();
    for (int k = 0; k < N; k++) begin src_re[k] = 0; src_im[k] = 0; end
    src_re[0] = 100;
    run_frame(1'b0, 0, N - 1);
  endtask

  task automatic test_dc_roundtrip();
    for (int k = 0; k < N; k++) begin src_re[k] = 10; src_im[k] = 0; end
    run_frame(1'b0, 0, N - 1);
    for (int k = 0; k < N; k++) begin src_re[k] = exp_re[k]; src_im[k] = exp_im[k]; end
    run_frame(1'b1, 0, N - 1);
  endtask

  task automatic test_backpressure();
    randomize_src();
    run_frame(1'b0, 1, N - 1);
  endtask

  task automatic test_early_last();
    int starts;
    randomize_src();
    send_frame(6, 5, 1'b0);
    n_tests++;
    if (frame_err !== 1'b1 || fft_start !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL early_last err=%b start=%b s_ready=%b want 1/0/1", frame_err, fft_start, s_ready);
    end
    starts = 0;
    tick();
    n_tests++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL early_err_width got=%b want=0", frame_err); end
    for (int i = 0; i < 4; i++) begin
      if (fft_start) starts++;
      tick();
    end
    n_tests++;
    if (starts != 0) begin n_fail++; $display("FAIL early_no_start got=%0d want=0", starts); end
    randomize_src();
    run_frame(1'b1, 2, N - 1);
  endtask

  task automatic test_missing_last();
    randomize_src();
    run_frame(1'b0, 0, -1);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      randomize_src();
      run_frame(bit'($urandom_range(0, 1)), 2, N - 1);
    end
  endtask

  task automatic test_timeout();
    int cycles, vcnt;
    core_dead = 1'b1;
    randomize_src();
    send_frame(N, N - 1, 1'b0);
    n_tests++;
    if (fft_start !== 1'b1) begin n_fail++; $display("FAIL to_start got=%b want=1", fft_start); end
    cycles = 0; vcnt = 0;
    while (!frame_err && cycles < 100) begin
      tick();
      cycles++;
      if (m_valid) vcnt++;
    end
    n_tests++;
    if (cycles != TO) begin n_fail++; $display("FAIL timeout_cycles got=%0d want=%0d", cycles, TO); end
    n_tests++;
    if (s_ready !== 1'b1 || vcnt != 0) begin
      n_fail++;
      $display("FAIL timeout_exit s_ready=%b beats=%0d want 1/0", s_ready, vcnt);
    end
    core_dead = 1'b0;
    tick();
    randomize_src();
    run_frame(1'b0, 0, N - 1);
  endtask

  task automatic test_reset_mid_wait();
    int nz, bad;
    randomize_src();
    send_frame(N, N - 1, 1'b1);
    tick(); tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({s_ready, fft_start, fft_mode, m_valid, m_last, frame_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrst_flags got=%b want=000000",
               {s_ready, fft_start, fft_mode, m_valid, m_last, frame_err});
    end
    nz = 0;
    for (int k = 0; k < N; k++) if (fft_real_in[k] !== '0 || fft_imag_in[k] !== '0) nz++;
    n_tests++;
    if (nz != 0) begin n_fail++; $display("FAIL midrst_frame nonzero got=%0d want=0", nz); end
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got=%b want=0", s_ready); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (frame_err || fft_start) bad++;
    end
    n_tests++;
    if (s_ready !== 1'b1 || bad != 0) begin
      n_fail++;
      $display("FAIL midrst_recover s_ready=%b spurious=%0d want 1/0", s_ready, bad);
    end
    randomize_src();
    run_frame(1'b0, 2, N - 1);
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_mode = 1'b0;
    s_real = '0; s_imag = '0; m_ready = 1'b0;
    test_reset();
    test_impulse();
    test_dc_roundtrip();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_random_frames();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
